pixel_config_sequencer: RTL and testbench
=========================================

# pixel_config_sequencer

Sequencer for the MIC4 pixel-configuration path, on SYS_CLK between the control-interface memory and the pixel-config write/start inputs. It configures one row at a time: streams that row's words from memory into the pixel-config FIFO, pulses the config start, then tracks the shifter's BUSY handshake before moving to the next row. It reports ACTIVE/DONE/ERROR status to the control interface and supports abort and a busy-rise timeout.

## Interface
- WORDS_PER_ROW, 8 — 32-bit memory words per pixel row (≥1)
- ROW_W, 8 — row counter width
- ADDR_W, 16 — memory address width (≥ clog2(2**ROW_W × WORDS_PER_ROW))
- TIMEOUT, 65535 — SYS_CLK cycles allowed for synced BUSY to rise after a kick
- SYS_CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- CMD_START  in  1  one-cycle pulse: configure rows 0..ROW_COUNT-1
- ABORT  in  1  one-cycle pulse: stop sequence
- ROW_COUNT  in  ROW_W  rows to configure; sampled on an accepted CMD_START
- MEM_RD_EN  out  1  memory read strobe
- MEM_ADDR  out  ADDR_W  memory word address
- MEM_DATA  in  32  read data, valid exactly 1 cycle after MEM_RD_EN
- FIFO_DATA  out  32  word to the pixel-config FIFO (equals MEM_DATA)
- FIFO_WE  out  1  FIFO write strobe (MEM_RD_EN delayed 1 cycle)
- CFG_START  out  1  one-cycle start pulse to the config pulse synchroniser
- CFG_BUSY  in  1  busy from the slow-clock shifter (asynchronous)
- ROW_SEL  out  ROW_W  row currently being configured
- ACTIVE  out  1  high in any non-IDLE state
- DONE  out  1  one-cycle pulse after the final row completes
- ERROR  out  1  sticky timeout flag; cleared by the next accepted CMD_START

## Operation
- States: IDLE, FETCH, DRAIN, KICK, WAIT_HI, WAIT_LO, NEXT.
- IDLE: accepts CMD_START.
  - ROW_COUNT=0: DONE pulses on the next cycle and the state stays IDLE.
  - Otherwise: latch the row count, set ROW_SEL=0, address counter=0, clear ERROR, go to FETCH.
- FETCH: assert MEM_RD_EN and MEM_ADDR each cycle for WORDS_PER_ROW consecutive cycles. The address increments by 1 per word and continues across rows, so row r starts at r×WORDS_PER_ROW. Go to DRAIN after the last word.
- DRAIN: one cycle so the last FIFO_WE completes. Then go to KICK.
- KICK: CFG_START=1 for one cycle. Clear the timeout counter. Go to WAIT_HI.
- WAIT_HI: wait for busy_s (CFG_BUSY after the 2-flop synchroniser) =1, then go to WAIT_LO.
  - The timeout counter increments every cycle.
  - When the counter reaches TIMEOUT: set ERROR, go to IDLE, no DONE.
- WAIT_LO: wait for busy_s=0. No timeout applies here. Then go to NEXT.
- NEXT:
  - If ROW_SEL = count−1: pulse DONE, go to IDLE.
  - Otherwise: increment ROW_SEL, go to FETCH.
- ABORT in any non-IDLE state:
  - Next state is IDLE. No DONE; ERROR is unchanged.
  - MEM_RD_EN drops in the same cycle, because it is decoded combinationally from state, and FIFO_WE may still fire once for the read already in flight.
  - FIFO contents are not flushed; firmware issues RESET to flush.
- Precedence:
  - CMD_START while ACTIVE is ignored.
  - CMD_START together with ABORT in IDLE: ABORT wins and the sequencer stays IDLE.
  - ABORT together with the timeout: the state goes to IDLE and ERROR is set.
- Address arithmetic: the address counter is ADDR_W bits and wraps modulo 2**ADDR_W. A configuration with row count × WORDS_PER_ROW > 2**ADDR_W is illegal.

## Timing
- Reset values: all outputs 0, state IDLE, synchroniser flops 0.
- CMD_START accepted in cycle T:
  - First MEM_RD_EN in T+1.
  - FIFO_WE at T+2 … T+1+WORDS_PER_ROW.
  - CFG_START at T+WORDS_PER_ROW+3.
- busy_s lags CFG_BUSY by 2 cycles.
- Minimum row period is WORDS_PER_ROW+5 cycles plus the BUSY high time plus the synchroniser delays.
- After the last row's busy_s falls, DONE pulses 2 cycles later: one cycle in WAIT_LO to detect the fall, then one in NEXT.
- ACTIVE falls in the same cycle that DONE is high.

## Structure
- Shared package pixel_cfg_pkg holds:
  - the state enum
  - default constants WORDS_PER_ROW_DEF and TIMEOUT_DEF
- One sub-module, sync_2ff: a 2-flop synchroniser for CFG_BUSY with asynchronous reset to 0.
- Counters: row (ROW_W bits), word (clog2(WORDS_PER_ROW+1) bits), address (ADDR_W bits), timeout (clog2(TIMEOUT+1) bits).

## Test plan
- Basic run: WORDS_PER_ROW=4, ROW_COUNT=2, BUSY model rises 10 cycles after CFG_START and stays high 20 cycles.
  - MEM_ADDR sequence 0..7; 8 FIFO_WE pulses carrying the memory data.
  - 2 CFG_START pulses; ROW_SEL goes 0→1.
  - DONE exactly once; ERROR=0.
- Zero rows: ROW_COUNT=0 → DONE one cycle after CMD_START; no MEM_RD_EN and no CFG_START.
- Timeout: TIMEOUT=50, BUSY held at 0 → ERROR set 50 cycles after entering WAIT_HI; no DONE.
  - A following CMD_START clears ERROR.
- Abort during FETCH: ABORT on the 2nd word → MEM_RD_EN low in the same cycle, at most 1 further FIFO_WE, IDLE next cycle, no DONE.
- Abort during WAIT_LO, then restart: next run starts at MEM_ADDR 0.
- Ignored start and reset:
  - CMD_START pulsed during WAIT_HI → no effect on the sequence.
  - RESET asserted mid-FETCH → all outputs 0 immediately (asynchronously).
  - Operation resumes correctly after RESET is released.

Source files
------------

// File: rtl/pixel_cfg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pixel_cfg_pkg : shared state encoding and defaults for the MIC4  |
// | pixel-configuration sequencer.                      Rev 1.0      |
// +------------------------------------------------------------------+
package pixel_cfg_pkg;

  localparam int WORDS_PER_ROW_DEF = 8;
  localparam int TIMEOUT_DEF       = 65535;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_KICK    = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_WAIT_LO = 3'd5,
    ST_NEXT    = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_config_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pixel_config_sequencer_if : control, memory, FIFO and shifter    |
// | handshake bundle of the sequencer.                  Rev 1.0      |
// +------------------------------------------------------------------+
interface pixel_config_sequencer_if #(
  parameter int ROW_W  = 8,
  parameter int ADDR_W = 16
);
  logic              CMD_START;
  logic              ABORT;
  logic [ROW_W-1:0]  ROW_COUNT;
  logic              MEM_RD_EN;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_DATA;
  logic [31:0]       FIFO_DATA;
  logic              FIFO_WE;
  logic              CFG_START;
  logic              CFG_BUSY;
  logic [ROW_W-1:0]  ROW_SEL;
  logic              ACTIVE;
  logic              DONE;
  logic              ERROR;

  // master is the sequencer, slave is everything around it
  modport master (
    input  CMD_START, ABORT, ROW_COUNT, MEM_DATA, CFG_BUSY,
    output MEM_RD_EN, MEM_ADDR, FIFO_DATA, FIFO_WE, CFG_START,
           ROW_SEL, ACTIVE, DONE, ERROR
  );

  modport slave (
    output CMD_START, ABORT, ROW_COUNT, MEM_DATA, CFG_BUSY,
    input  MEM_RD_EN, MEM_ADDR, FIFO_DATA, FIFO_WE, CFG_START,
           ROW_SEL, ACTIVE, DONE, ERROR
  );
endinterface
`default_nettype wire

// File: rtl/pixel_config_sequencer_sync_2ff.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_2ff : two-flop synchroniser, asynchronous reset to 0.       |
// |                                                     Rev 1.0      |
// +------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d_async;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/pixel_config_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pixel_config_sequencer : streams one pixel row at a time from    |
// | memory into the config FIFO, kicks the shifter, tracks BUSY.     |
// |                                                     Rev 1.0      |
// +------------------------------------------------------------------+
module pixel_config_sequencer
  import pixel_cfg_pkg::*;
#(
  parameter int WORDS_PER_ROW = WORDS_PER_ROW_DEF,
  parameter int ROW_W         = 8,
  parameter int ADDR_W        = 16,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                     SYS_CLK,
  input  logic                     RESET,
  pixel_config_sequencer_if.master bus
);

  localparam int c_wcnt_w = $clog2(WORDS_PER_ROW + 1);
  localparam int c_tcnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_wcnt_w-1:0] c_word_last = c_wcnt_w'(WORDS_PER_ROW - 1);
  localparam logic [c_tcnt_w-1:0] c_timeout   = c_tcnt_w'(TIMEOUT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_wcnt_w-1:0] r_word_cnt;
  logic [c_tcnt_w-1:0] r_tcnt;
  logic [c_tcnt_w-1:0] w_tcnt_inc;
  logic [ADDR_W-1:0]   r_addr;
  logic [ROW_W-1:0]    r_row_sel;
  logic [ROW_W-1:0]    r_row_last;
  logic                r_fifo_we;
  logic                r_cfg_start;
  logic                r_done;
  logic                r_error;
  logic                w_busy_s;
  logic                w_rd_en;
  logic                w_accept;
  logic                w_zero_done;
  logic                w_last_done;
  logic                w_timeout;

  sync_2ff u_busy_sync (
    .clk     (SYS_CLK),
    .rst     (RESET),
    .d_async (bus.CFG_BUSY),
    .q       (w_busy_s)
  );

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_accept    = 1'b0;
    w_zero_done = 1'b0;
    w_last_done = 1'b0;
    w_timeout   = 1'b0;
    w_tcnt_inc  = r_tcnt + 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (bus.CMD_START && !bus.ABORT) begin
          if (bus.ROW_COUNT == '0) begin
            w_zero_done = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        w_rd_en = 1'b1;
        if (r_word_cnt == c_word_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN:   w_state_nxt = ST_KICK;
      ST_KICK:    w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (w_busy_s) begin
          w_state_nxt = ST_WAIT_LO;
        end else if (w_tcnt_inc == c_timeout) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_LO: begin
        if (!w_busy_s) w_state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        if (r_row_sel == r_row_last) begin
          w_last_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Abort overrides everything except a coincident timeout, which still flags ERROR
    if (bus.ABORT && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_rd_en     = 1'b0;
      w_last_done = 1'b0;
    end
  end

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      r_word_cnt  <= '0;
      r_tcnt      <= '0;
      r_addr      <= '0;
      r_row_sel   <= '0;
      r_row_last  <= '0;
      r_fifo_we   <= 1'b0;
      r_cfg_start <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (r_state != ST_FETCH) r_word_cnt <= '0;
      else if (w_rd_en)        r_word_cnt <= r_word_cnt + 1'b1;

      if (r_state == ST_KICK)         r_tcnt <= '0;
      else if (r_state == ST_WAIT_HI) r_tcnt <= w_tcnt_inc;

      // Address runs continuously across rows so row r begins at r*WORDS_PER_ROW
      if (w_accept)     r_addr <= '0;
      else if (w_rd_en) r_addr <= r_addr + 1'b1;

      if (w_accept) begin
        r_row_sel  <= '0;
        r_row_last <= bus.ROW_COUNT - 1'b1;
      end else if ((r_state == ST_NEXT) && (w_state_nxt == ST_FETCH)) begin
        r_row_sel  <= r_row_sel + 1'b1;
      end

      if (w_accept)       r_error <= 1'b0;
      else if (w_timeout) r_error <= 1'b1;

      r_fifo_we   <= w_rd_en;
      r_cfg_start <= (r_state == ST_KICK) && (w_state_nxt == ST_WAIT_HI);
      r_done      <= w_zero_done | w_last_done;
    end
  end

  assign bus.MEM_RD_EN = w_rd_en;
  assign bus.MEM_ADDR  = r_addr;
  assign bus.FIFO_WE   = r_fifo_we;
  assign bus.FIFO_DATA = r_fifo_we ? bus.MEM_DATA : 32'd0;
  assign bus.CFG_START = r_cfg_start;
  assign bus.ROW_SEL   = r_row_sel;
  assign bus.ACTIVE    = (r_state != ST_IDLE);
  assign bus.DONE      = r_done;
  assign bus.ERROR     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_pixel_config_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pixel_config_sequencer : directed self-checking bench with a  |
// | transaction-level expectation model.                Rev 1.0      |
// +------------------------------------------------------------------+
module tb_pixel_config_sequencer;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   tmr;
  bit   busy_en;

  int          exp_rd[$];
  logic [31:0] exp_we[$];
  int          exp_row[$];
  int          cfg_cycles[$];
  int          done_cycles[$];
  int          first_rd;
  int          err_rise;
  logic        prev_err;
  int          t0;

  pixel_config_sequencer_if #(.ROW_W(8), .ADDR_W(16)) bus ();

  pixel_config_sequencer #(
    .WORDS_PER_ROW (W),
    .ROW_W         (8),
    .ADDR_W        (16),
    .TIMEOUT       (50)
  ) dut (
    .SYS_CLK (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input int a);
    logic [15:0] lo;
    lo = a[15:0];
    return {16'hC0DE, lo};
  endfunction

  // Synchronous memory: data valid one cycle after the read strobe
  always @(posedge clk)
    bus.MEM_DATA <= bus.MEM_RD_EN ? {16'hC0DE, bus.MEM_ADDR} : 32'hDEAD_BEEF;

  // Shifter: BUSY rises 10 cycles after CFG_START and stays high 20 cycles
  initial tmr = 0;
  always @(posedge clk) begin
    if (bus.CFG_START && busy_en) tmr <= 1;
    else if (tmr != 0 && tmr < 30) tmr <= tmr + 1;
    else tmr <= 0;
  end
  assign bus.CFG_BUSY = (tmr >= 10) && (tmr <= 29);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected transactions of a run: words 0..n_words-1 in order, kicks for rows 0..rows-1
  task automatic plan(input int rows, input int n_words);
    for (int i = 0; i < n_words; i++) begin
      exp_rd.push_back(i);
      exp_we.push_back(mem_word(i));
    end
    for (int r = 0; r < rows; r++) exp_row.push_back(r);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.MEM_RD_EN) begin
        if (first_rd < 0) first_rd = cyc;
        check("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) check("rd_addr", 64'(bus.MEM_ADDR), 64'(exp_rd.pop_front()));
      end
      if (bus.FIFO_WE) begin
        check("we_expected", 64'(exp_we.size() != 0), 64'd1);
        if (exp_we.size() != 0) check("we_data", 64'(bus.FIFO_DATA), 64'(exp_we.pop_front()));
      end
      if (bus.CFG_START) begin
        cfg_cycles.push_back(cyc);
        check("kick_expected", 64'(exp_row.size() != 0), 64'd1);
        if (exp_row.size() != 0) check("kick_row_sel", 64'(bus.ROW_SEL), 64'(exp_row.pop_front()));
      end
      if (bus.DONE) begin
        done_cycles.push_back(cyc);
        check("done_active_low", 64'(bus.ACTIVE), 64'd0);
      end
      if (bus.ERROR && !prev_err) err_rise = cyc;
      prev_err = bus.ERROR;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input int rows);
    bus.CMD_START = 1'b1;
    bus.ROW_COUNT = 8'(rows);
    t0 = cyc;
    tick(1);
    bus.CMD_START = 1'b0;
  endtask

  task automatic end_check(input string tag, input int n_cfg, input int n_done, input logic err);
    check({tag, "_rd_left"},   64'(exp_rd.size()),      64'd0);
    check({tag, "_we_left"},   64'(exp_we.size()),      64'd0);
    check({tag, "_kick_left"}, 64'(exp_row.size()),     64'd0);
    check({tag, "_kicks"},     64'(cfg_cycles.size()),  64'(n_cfg));
    check({tag, "_dones"},     64'(done_cycles.size()), 64'(n_done));
    check({tag, "_error"},     64'(bus.ERROR),          64'(err));
    check({tag, "_idle"},      64'(bus.ACTIVE),         64'd0);
    exp_rd.delete();
    exp_we.delete();
    exp_row.delete();
    cfg_cycles.delete();
    done_cycles.delete();
    first_rd = -1;
    err_rise = -1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},   64'(bus.MEM_RD_EN), 64'd0);
    check({tag, "_addr"},    64'(bus.MEM_ADDR),  64'd0);
    check({tag, "_we"},      64'(bus.FIFO_WE),   64'd0);
    check({tag, "_fdata"},   64'(bus.FIFO_DATA), 64'd0);
    check({tag, "_start"},   64'(bus.CFG_START), 64'd0);
    check({tag, "_row_sel"}, 64'(bus.ROW_SEL),   64'd0);
    check({tag, "_active"},  64'(bus.ACTIVE),    64'd0);
    check({tag, "_done"},    64'(bus.DONE),      64'd0);
    check({tag, "_error"},   64'(bus.ERROR),     64'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    first_rd = -1; err_rise = -1; prev_err = 1'b0;
    busy_en = 1'b1;
    rst = 1'b1;
    bus.CMD_START = 1'b0;
    bus.ABORT     = 1'b0;
    bus.ROW_COUNT = '0;
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    // Basic two-row run; cycle numbers are relative to the accepted start
    plan(2, 2 * W);
    start(2);
    tick(95);
    check("basic_first_rd", 64'(first_rd), 64'(t0 + 1));
    if (cfg_cycles.size() == 2) begin
      check("basic_kick0_cyc", 64'(cfg_cycles[0]), 64'(t0 + 7));
      check("basic_kick1_cyc", 64'(cfg_cycles[1]), 64'(t0 + 47));
    end
    if (done_cycles.size() == 1) check("basic_done_cyc", 64'(done_cycles[0]), 64'(t0 + 81));
    end_check("basic", 2, 1, 1'b0);

    // Zero rows: DONE next cycle, nothing else
    start(0);
    check("zero_done_now", 64'(bus.DONE), 64'd1);
    tick(3);
    if (done_cycles.size() == 1) check("zero_done_cyc", 64'(done_cycles[0]), 64'(t0 + 1));
    end_check("zero", 0, 1, 1'b0);

    // Timeout: BUSY never rises, WAIT_HI entered at t0+7, ERROR 50 cycles later
    busy_en = 1'b0;
    plan(1, W);
    start(1);
    tick(70);
    check("timeout_err_cyc", 64'(err_rise), 64'(t0 + 57));
    end_check("timeout", 1, 0, 1'b1);
    busy_en = 1'b1;
    plan(1, W);
    start(1);
    check("restart_err_clear", 64'(bus.ERROR), 64'd0);
    tick(50);
    if (done_cycles.size() == 1) check("restart_done_cyc", 64'(done_cycles[0]), 64'(t0 + 41));
    end_check("restart", 1, 1, 1'b0);

    // Abort on the second fetch word
    plan(0, 1);
    start(2);
    tick(1);
    bus.ABORT = 1'b1;
    @(negedge clk);
    check("abort_fetch_rd_low", 64'(bus.MEM_RD_EN), 64'd0);
    @(posedge clk); #1;
    bus.ABORT = 1'b0;
    check("abort_fetch_idle", 64'(bus.ACTIVE), 64'd0);
    tick(10);
    end_check("abort_fetch", 0, 0, 1'b0);

    // Abort while waiting for BUSY to fall, then a fresh run from address 0
    plan(1, W);
    start(2);
    tick(24);
    bus.ABORT = 1'b1;
    tick(1);
    bus.ABORT = 1'b0;
    check("abort_wlo_idle", 64'(bus.ACTIVE), 64'd0);
    tick(60);
    end_check("abort_wlo", 1, 0, 1'b0);
    plan(2, 2 * W);
    start(2);
    tick(95);
    check("rerun_first_rd", 64'(first_rd), 64'(t0 + 1));
    end_check("rerun", 2, 1, 1'b0);

    // Asynchronous reset in the middle of FETCH
    plan(0, 1);
    exp_we.delete();
    start(2);
    tick(1);
    #1 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    tick(2);
    rst = 1'b0;
    end_check("async_rst", 0, 0, 1'b0);

    // Resume after reset; a CMD_START during WAIT_HI must be ignored
    plan(2, 2 * W);
    start(2);
    tick(9);
    bus.CMD_START = 1'b1;
    bus.ROW_COUNT = 8'd5;
    tick(1);
    bus.CMD_START = 1'b0;
    tick(85);
    if (cfg_cycles.size() == 2) check("ignore_kick1_cyc", 64'(cfg_cycles[1]), 64'(t0 + 47));
    if (done_cycles.size() == 1) check("ignore_done_cyc", 64'(done_cycles[0]), 64'(t0 + 81));
    end_check("ignore_start", 2, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
